// File: rtl/param_seq_multiplier.sv
// param_seq_multiplier
//   Sequential shift-add multiplier with a WIDTH-bit operand width and a
//   per-operation signed/unsigned mode. The Start/Done/Ack handshake runs
//   IDLE -> CALC (WIDTH steps) -> DONE -> IDLE.
//
// Ports
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous active-low reset
//   Start         in   operation request, sampled only in IDLE
//   Ack           in   result acknowledge, sampled only in DONE
//   Signed_Mode   in   1 = two's-complement operands, sampled with Start
//   Multiplier_Q  in   multiplicand, sampled with Start
//   Multiplier_R  in   multiplier, sampled with Start
//   Multiplier_P  out  registered 2*WIDTH-bit product, held until next result
//   Done          out  high in DONE
//   Busy          out  high in CALC
module param_seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Ack,
    input  logic                 Signed_Mode,
    input  logic [WIDTH-1:0]     Multiplier_Q,
    input  logic [WIDTH-1:0]     Multiplier_R,
    output logic [2*WIDTH-1:0]   Multiplier_P,
    output logic                 Done,
    output logic                 Busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0]   OneW = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] OneP = (2*WIDTH)'(1);
    localparam logic [CntW-1:0]    OneC = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_reg_q, q_reg_d;
    logic [WIDTH-1:0]     r_reg_q, r_reg_d;
    logic                 neg_q, neg_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    // Upper half of the accumulator is WIDTH+1 bits so the add carry is kept.
    logic [WIDTH:0]       upper_sum;
    logic [2*WIDTH:0]     acc_shift;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_reg_d   = q_reg_q;
        r_reg_d   = r_reg_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        upper_sum = acc_q[2*WIDTH:WIDTH];
        acc_shift = acc_q;

        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StCalc;
                    acc_d   = '0;
                    cnt_d   = CntW'(WIDTH);
                    if (Signed_Mode) begin
                        // Magnitude of the most-negative value wraps to 2^(WIDTH-1),
                        // which is exactly right as an unsigned magnitude.
                        q_reg_d = Multiplier_Q[WIDTH-1] ? (~Multiplier_Q + OneW) : Multiplier_Q;
                        r_reg_d = Multiplier_R[WIDTH-1] ? (~Multiplier_R + OneW) : Multiplier_R;
                        neg_d   = Multiplier_Q[WIDTH-1] ^ Multiplier_R[WIDTH-1];
                    end else begin
                        q_reg_d = Multiplier_Q;
                        r_reg_d = Multiplier_R;
                        neg_d   = 1'b0;
                    end
                end
            end

            StCalc: begin
                if (r_reg_q[0]) begin
                    upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, q_reg_q};
                end
                acc_shift = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
                acc_d     = acc_shift;
                r_reg_d   = r_reg_q >> 1;
                cnt_d     = cnt_q - OneC;
                if (cnt_q == OneC) begin
                    state_d = StDone;
                    // Negating zero gives zero, so no negative-zero pattern exists.
                    p_d     = neg_q ? (~acc_shift[2*WIDTH-1:0] + OneP)
                                    : acc_shift[2*WIDTH-1:0];
                end
            end

            StDone: begin
                if (Ack) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            q_reg_q <= '0;
            r_reg_q <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_reg_q <= q_reg_d;
            r_reg_q <= r_reg_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Outputs decode registered state only; no input-to-output path.
    assign Multiplier_P = p_q;
    assign Done         = (state_q == StDone);
    assign Busy         = (state_q == StCalc);

endmodule
